// File: rtl/uart_rx_pkg.sv
// Shared definitions for the J1 UART receive peripheral: register offsets,
// STATUS/CTRL bit positions, receiver FSM state encoding and the STATUS
// word packer used by the read mux.
// Optional feature macro: UART_RX_PARITY_EN (8E1 framing when defined).
package uart_rx_pkg;

  // Register offsets on j1_io_addr[3:0]
  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h2;
  localparam logic [3:0] REG_CTRL   = 4'h4;

  // STATUS bit positions
  localparam int STAT_NOT_EMPTY  = 0;
  localparam int STAT_FULL       = 1;
  localparam int STAT_OVERRUN    = 2;
  localparam int STAT_FRAME_ERR  = 3;
  localparam int STAT_PARITY_ERR = 4;
  localparam int STAT_COUNT_LSB  = 8;

  // CTRL bit positions
  localparam int CTRL_CLR_FLAGS = 0;
  localparam int CTRL_FLUSH     = 1;

  // Receiver FSM states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_e;

  // Assemble the STATUS word; unused bits read as zero.
  function automatic logic [15:0] pack_status(
    input logic       not_empty,
    input logic       full,
    input logic       overrun,
    input logic       frame_err,
    input logic       parity_err,
    input logic [6:0] count
  );
    logic [15:0] s;
    s = 16'h0000;
    s[STAT_NOT_EMPTY]  = not_empty;
    s[STAT_FULL]       = full;
    s[STAT_OVERRUN]    = overrun;
    s[STAT_FRAME_ERR]  = frame_err;
    s[STAT_PARITY_ERR] = parity_err;
    s[STAT_COUNT_LSB +: 7] = count;
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO: power-of-two depth, wrapping pointers and a
// count one bit wider than the pointers. Flush overrides push and pop in the
// same cycle. A push while full is accepted only when a pop frees a slot.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i & ~empty_o & ~flush_i;
  assign push_ok = push_i & ~flush_i & (~full_o | pop_ok);

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful below the count
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/peripheral_uart_rx.sv
// J1 UART receive peripheral: 2-FF synchronizer, baud counter, deframing
// FSM, receive FIFO and the cs/addr/rd/wr register interface.
// Optional feature macro: UART_RX_PARITY_EN (adds a PARITY state, 8E1).
// Bus handshake: a read is the rising edge of cs&rd; d_out is loaded on that
// edge and held until the next read, and a DATA read pops at most once per
// rising edge. Writes to CTRL act on every cycle cs&wr is high.
module peripheral_uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  input  logic        uart_rx,
  output logic        rx_irq
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] CNT_FULL = 16'(BAUD_DIV);
  localparam logic [15:0] CNT_HALF = 16'(BAUD_DIV / 2);

  // Synchronizer and edge detect
  logic sync1_q, sync2_q, rx_prev_q;
  logic rx_s, rx_fall;

  // FSM and bit-timing datapath
  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        cnt_expire;
  logic        cnt_load;
  logic [15:0] cnt_load_val;
  logic        bit_clr, shift_en, push_req, frame_set;
`ifdef UART_RX_PARITY_EN
  logic        par_set;
  logic        par_bad_q, par_bad_d;
  logic        parity_err_q;
`endif

  // Bus side
  logic        rd_q, rd_rise, wr_ctrl, flag_clr, flush, pop;
  logic [15:0] d_out_q, rd_data;
  logic        rx_irq_q;
  logic        overrun_q, frame_err_q, parity_err;
  logic        overrun_set;

  // FIFO
  logic [7:0]  fifo_head;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_count;

  // Upper CTRL bits carry no function
  logic        unused_d_in;
  assign unused_d_in = ^d_in[15:2];

  assign rx_s       = sync2_q;
  assign rx_fall    = rx_prev_q & ~sync2_q;
  assign cnt_expire = (cnt_q <= 16'd1);

  // Bring the async serial line into the clk domain; idle high out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= uart_rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (rx_fall) state_d = S_START;
      S_START:  if (cnt_expire) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (cnt_expire && (bit_idx_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
      S_PARITY: if (cnt_expire) state_d = S_STOP;
      S_STOP:   if (cnt_expire) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: counter reloads on state entry, sampling strobes, push/flags
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = CNT_FULL;
    bit_clr      = 1'b0;
    shift_en     = 1'b0;
    push_req     = 1'b0;
    frame_set    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_set      = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (rx_fall) begin
          cnt_load     = 1'b1;
          cnt_load_val = CNT_HALF;
        end
      end
      S_START: begin
        if (cnt_expire && !rx_s) begin
          cnt_load = 1'b1;
          bit_clr  = 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_expire) begin
          shift_en = 1'b1;
          cnt_load = 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt_expire) begin
          cnt_load = 1'b1;
`ifdef UART_RX_PARITY_EN
          // Even parity: the parity bit equals the XOR of the data bits
          par_set  = (rx_s != ^shift_q);
`endif
        end
      end
      S_STOP: begin
        if (cnt_expire) begin
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            push_req = ~par_bad_q;
`else
            push_req = 1'b1;
`endif
          end else begin
            frame_set = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Bit-timing datapath next-state
  always_comb begin
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    if (cnt_load)             cnt_d = cnt_load_val;
    else if (cnt_q != 16'd0)  cnt_d = cnt_q - 16'd1;
    if (bit_clr)              bit_idx_d = 3'd0;
    else if (shift_en)        bit_idx_d = bit_idx_q + 3'd1;
    if (shift_en)             shift_d = {rx_s, shift_q[7:1]};
  end

  // Bit-timing datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Remember a parity mismatch until the frame's STOP decision
  always_comb begin
    par_bad_d = par_bad_q;
    if (bit_clr)      par_bad_d = 1'b0;
    else if (par_set) par_bad_d = 1'b1;
  end

  // Parity-tracking registers; set beats clear on the sticky flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q    <= par_bad_d;
      parity_err_q <= par_set | (parity_err_q & ~flag_clr);
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // Bus decode
  assign rd_rise     = cs & rd & ~rd_q;
  assign wr_ctrl     = cs & wr & (addr == REG_CTRL);
  assign flag_clr    = wr_ctrl & d_in[CTRL_CLR_FLAGS];
  assign flush       = wr_ctrl & d_in[CTRL_FLUSH];
  assign pop         = rd_rise & (addr == REG_DATA) & ~fifo_empty;
  assign overrun_set = push_req & fifo_full & ~pop & ~flush;

  // Read data selection; empty DATA and unmapped offsets read as zero
  always_comb begin
    rd_data = 16'h0000;
    case (addr)
      REG_DATA:   if (!fifo_empty) rd_data = {8'h00, fifo_head};
      REG_STATUS: rd_data = pack_status(~fifo_empty, fifo_full, overrun_q,
                                        frame_err_q, parity_err, 7'(fifo_count));
      default:    rd_data = 16'h0000;
    endcase
  end

  // Bus registers: read strobe history, held read data, irq and sticky flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q        <= 1'b0;
      d_out_q     <= 16'h0000;
      rx_irq_q    <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rd_q        <= cs & rd;
      if (rd_rise) d_out_q <= rd_data;
      rx_irq_q    <= ~fifo_empty;
      overrun_q   <= overrun_set | (overrun_q & ~flag_clr);
      frame_err_q <= frame_set | (frame_err_q & ~flag_clr);
    end
  end

  assign d_out  = d_out_q;
  assign rx_irq = rx_irq_q;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push_req),
    .data_i  (shift_q),
    .pop_i   (pop),
    .flush_i (flush),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_peripheral_uart_rx.sv
// Bench for peripheral_uart_rx at BAUD_DIV=16, FIFO_DEPTH=8. Bytes that the
// receiver should keep are queued in exp_q as they are sent and popped when
// DATA is read back. The parity section is built only with UART_RX_PARITY_EN.
module tb_peripheral_uart_rx;
  import uart_rx_pkg::*;

  localparam int BAUD  = 16;
  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic [15:0] d_in;
  logic        cs;
  logic [3:0]  addr;
  logic        rd;
  logic        wr;
  logic [15:0] d_out;
  logic        uart_rx;
  logic        rx_irq;

  logic [15:0] exp_q[$];
  int          n_total;
  int          n_bad;

  peripheral_uart_rx #(
    .BAUD_DIV   (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .d_in    (d_in),
    .cs      (cs),
    .addr    (addr),
    .rd      (rd),
    .wr      (wr),
    .d_out   (d_out),
    .uart_rx (uart_rx),
    .rx_irq  (rx_irq)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Expected STATUS word built from individual fields
  function automatic logic [15:0] status_word(input int cnt, input bit ovr, input bit fe, input bit pe);
    logic [15:0] s;
    s = 16'h0000;
    s[0] = (cnt != 0);
    s[1] = (cnt == DEPTH);
    s[2] = ovr;
    s[3] = fe;
    s[4] = pe;
    s[14:8] = 7'(cnt);
    return s;
  endfunction

  // Serial driver: start, 8 data bits LSB first, optional parity, stop
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = data[i];
      repeat (BAUD) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    uart_rx = par_bit;
    repeat (BAUD) @(negedge clk);
`else
    if (par_bit) uart_rx = 1'b1;
`endif
    uart_rx = stop_bit;
    repeat (BAUD) @(negedge clk);
    uart_rx = 1'b1;
    repeat (BAUD / 2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] data);
    send_frame(data, 1'b1, ^data);
  endtask

  // Bus read: one-cycle strobe, sample d_out on the following negedge
  task automatic bus_read(input logic [3:0] a, output logic [15:0] v);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    v = d_out;
    cs = 1'b0; rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [15:0] v);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = v;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; d_in = 16'h0000;
    @(negedge clk);
  endtask

  // Scoreboard read of DATA: expect the oldest queued byte or zero when none
  task automatic read_data_check(input string tag);
    logic [15:0] v, e;
    bus_read(REG_DATA, v);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'h0000;
    check_eq(tag, v, e);
  endtask

  task automatic read_status_check(input string tag, input logic [15:0] e);
    logic [15:0] v;
    bus_read(REG_STATUS, v);
    check_eq(tag, v, e);
  endtask

  // Watchdog so the run always ends
  initial begin
    #2ms;
    n_total++;
    n_bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    logic [15:0] v;
    n_total = 0;
    n_bad   = 0;
    rst = 1'b0; d_in = 16'h0000; cs = 1'b0; addr = 4'h0;
    rd = 1'b0; wr = 1'b0; uart_rx = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_dout", d_out, 16'h0000);
    check_eq("rst_irq", {15'd0, rx_irq}, 16'h0000);
    check_eq("rst_state", 16'(dut.state_q), 16'(S_IDLE));
    rst = 1'b1;
    repeat (4) @(negedge clk);
    read_status_check("rst_status", 16'h0000);

    // Single byte
    send_byte(8'hA5);
    exp_q.push_back(16'h00A5);
    read_status_check("a5_status", status_word(1, 0, 0, 0));
    check_eq("a5_irq", {15'd0, rx_irq}, 16'h0001);
    read_data_check("a5_data");
    read_status_check("a5_status_after", 16'h0000);
    check_eq("a5_irq_after", {15'd0, rx_irq}, 16'h0000);

    // Fill past capacity: ninth byte is dropped
    for (int i = 1; i <= 9; i++) begin
      send_byte(8'(i));
      if (i <= DEPTH) exp_q.push_back(16'(i));
    end
    read_status_check("ovr_status", status_word(DEPTH, 1, 0, 0));
    for (int i = 0; i <= DEPTH; i++) read_data_check($sformatf("ovr_data%0d", i));
    read_status_check("ovr_sticky", status_word(0, 1, 0, 0));
    bus_write(REG_CTRL, 16'h0001);
    read_status_check("ovr_clear", 16'h0000);

    // Framing error
    send_frame(8'h3C, 1'b0, ^8'h3C);
    read_status_check("fe_status", status_word(0, 0, 1, 0));
    bus_write(REG_CTRL, 16'h0001);
    read_status_check("fe_clear", 16'h0000);

    // Short glitch then a good byte
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * BAUD) @(negedge clk);
    check_eq("glitch_state", 16'(dut.state_q), 16'(S_IDLE));
    read_status_check("glitch_status", 16'h0000);
    send_byte(8'h5A);
    exp_q.push_back(16'h005A);
    read_data_check("glitch_5a");

    // Unmapped read and FIFO flush
    send_byte(8'h77);
    bus_read(4'h6, v);
    check_eq("unmapped_rd", v, 16'h0000);
    bus_write(REG_CTRL, 16'h0002);
    read_status_check("flush_status", 16'h0000);
    check_eq("flush_irq", {15'd0, rx_irq}, 16'h0000);

    // Long read strobe pops once
    send_byte(8'h11); exp_q.push_back(16'h0011);
    send_byte(8'h22); exp_q.push_back(16'h0022);
    send_byte(8'h33); exp_q.push_back(16'h0033);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = REG_DATA;
    repeat (5) @(negedge clk);
    check_eq("hold_data", d_out, exp_q.pop_front());
    cs = 1'b0; rd = 1'b0;
    @(negedge clk);
    read_status_check("hold_status", status_word(2, 0, 0, 0));

    // Reset in the middle of a frame
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    uart_rx = 1'b1;
    repeat (BAUD / 2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("midrst_dout", d_out, 16'h0000);
    check_eq("midrst_irq", {15'd0, rx_irq}, 16'h0000);
    check_eq("midrst_state", 16'(dut.state_q), 16'(S_IDLE));
    exp_q.delete();
    rst = 1'b1;
    repeat (4 * BAUD) @(negedge clk);
    read_status_check("midrst_status", 16'h0000);
    read_data_check("midrst_data");

`ifdef UART_RX_PARITY_EN
    // Wrong then correct even parity
    send_frame(8'h07, 1'b1, 1'b0);
    read_status_check("par_bad_status", status_word(0, 0, 0, 1));
    bus_write(REG_CTRL, 16'h0001);
    send_frame(8'h07, 1'b1, 1'b1);
    exp_q.push_back(16'h0007);
    read_status_check("par_ok_status", status_word(1, 0, 0, 0));
    read_data_check("par_ok_data");
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
